// File: rtl/sram_fifo_rd_unpacker.sv
// sram_fifo_rd_unpacker
//   Read-side consumer of sram_fifo. Issues credit-limited, non-adjacent rd_req pulses, collects the
//   returned lines in a PF_DEPTH-entry prefetch ring, and unpacks the head line LSB-first into
//   OUT_WIDTH-bit slices on a valid/ready stream. A flush empties the ring and discards every line
//   still in flight before normal operation resumes.
//   Optional build macro: SRAM_FIFO_RD_UNPACKER_STATS_EN adds the stall_cnt/starve_cnt outputs.
module sram_fifo_rd_unpacker #(
  parameter int SRAM_WRAP_WIDTH = 32,
  parameter int OUT_WIDTH       = 8,
  parameter int PF_DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [SRAM_WRAP_WIDTH-1:0] fifo_rd_data,
  input  logic                       fifo_rd_val,
  output logic                       fifo_rd_req,
  input  logic                       flush,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef SRAM_FIFO_RD_UNPACKER_STATS_EN
  output logic [15:0]                stall_cnt,
  output logic [15:0]                starve_cnt,
`endif
  output logic                       busy
);

  localparam int NSLC = SRAM_WRAP_WIDTH / OUT_WIDTH;
  localparam int CW   = $clog2(PF_DEPTH + 1);
  localparam int PW   = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int IW   = (NSLC > 1) ? $clog2(NSLC) : 1;

  // Reject configurations the slicing and credit logic cannot handle.
  if ((SRAM_WRAP_WIDTH % OUT_WIDTH) != 0 || NSLC < 2 || PF_DEPTH < 2) begin : g_param_err
    $error("sram_fifo_rd_unpacker: illegal SRAM_WRAP_WIDTH/OUT_WIDTH/PF_DEPTH combination");
  end

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  state_t                     state_q, state_d;
  logic   [CW-1:0]            outst_q, outst_d;   // rd_req issued, line not yet returned
  logic   [CW-1:0]            cnt_q,   cnt_d;     // lines held in the ring (head included)
  logic   [PW-1:0]            head_q,  head_d;
  logic   [PW-1:0]            tail_q,  tail_d;
  logic   [IW-1:0]            idx_q,   idx_d;     // slice index inside the head line
  logic                       req_prev_q;         // rd_req was high last cycle
  logic                       out_valid_d;
  logic   [OUT_WIDTH-1:0]     out_data_d;
  logic   [SRAM_WRAP_WIDTH-1:0] ring [PF_DEPTH];

  // ---------------------------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------------------------
  logic                       ret;        // legal return (an issued read is outstanding)
  logic                       wr_en;      // returned line is kept
  logic                       xfer;       // slice accepted by the consumer
  logic                       last_slice;
  logic                       pop;        // head line fully consumed
  logic   [CW:0]              used;       // credits in use: outstanding + buffered
  logic   [SRAM_WRAP_WIDTH-1:0] head_line;

  // A return with nothing outstanding is a protocol error and is dropped outright.
  assign ret        = fifo_rd_val && (outst_q != '0);
  // Lines returning during flush or DRAIN only release their credit.
  assign wr_en      = ret && (state_q == ST_RUN) && !flush;
  assign xfer       = out_valid && out_ready;
  assign last_slice = (idx_q == IW'(NSLC - 1));
  assign pop        = xfer && last_slice && !flush;
  assign used       = {1'b0, outst_q} + {1'b0, cnt_q};

  // Ring pointers wrap at PF_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(PF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------------

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // FSM next state: flush enters DRAIN; DRAIN exits once nothing is outstanding and flush is low.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (!flush && (outst_q == '0)) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs: read issue under credit/gap rules, and the busy summary.
  always_comb begin
    fifo_rd_req = 1'b0;
    if ((state_q == ST_RUN) && !rst && !flush && !fifo_empty && !req_prev_q &&
        (used < (CW+1)'(PF_DEPTH))) begin
      fifo_rd_req = 1'b1;
    end
    busy = (outst_q != '0) || (cnt_q != '0) || (state_q == ST_DRAIN);
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------------------------

  // Outstanding-read counter: issue and return in the same cycle cancel out.
  always_comb begin
    outst_d = outst_q;
    if (fifo_rd_req && !ret) begin
      outst_d = outst_q + CW'(1);
    end else if (!fifo_rd_req && ret) begin
      outst_d = outst_q - CW'(1);
    end
  end

  // Ring occupancy, pointers and slice index; flush empties the ring and restarts the index.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    idx_d  = idx_q;
    if (flush) begin
      cnt_d  = '0;
      head_d = '0;
      tail_d = '0;
      idx_d  = '0;
    end else begin
      if (wr_en) tail_d = ptr_inc(tail_q);
      if (pop)   head_d = ptr_inc(head_q);
      if (wr_en && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!wr_en && pop) begin
        cnt_d = cnt_q - CW'(1);
      end
      if (xfer) idx_d = last_slice ? '0 : idx_q + IW'(1);
    end
  end

  // Next output slice: when the next head is the line being written this cycle, take it from the
  // return bus because the ring entry only updates at the clock edge.
  always_comb begin
    head_line   = (wr_en && (head_d == tail_q)) ? fifo_rd_data : ring[head_d];
    out_valid_d = (cnt_d != '0);
    out_data_d  = '0;
    if (out_valid_d) out_data_d = head_line[idx_d*OUT_WIDTH +: OUT_WIDTH];
  end

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------

  // Control and output registers; out_valid/out_data come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q    <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      idx_q      <= '0;
      req_prev_q <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      outst_q    <= outst_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      idx_q      <= idx_d;
      req_prev_q <= fifo_rd_req;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
    end
  end

  // Prefetch ring storage, written at the tail on every kept return.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; cnt_q alone decides which entries are meaningful.
    if (wr_en) ring[tail_q] <= fifo_rd_data;
  end

`ifdef SRAM_FIFO_RD_UNPACKER_STATS_EN
  // Saturating stall and starvation counters, cleared by reset and by flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if ((state_q == ST_RUN) && (cnt_q == '0) && fifo_empty && (starve_cnt != 16'hFFFF)) begin
        starve_cnt <= starve_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_fifo_rd_unpacker.sv
// tb_sram_fifo_rd_unpacker
//   Directed bench: a FIFO model with programmable read latency feeds the unpacker. A vector
//   table drives the streaming scenarios; flush, reset and (optionally) statistics are separate
//   hand-written sequences.
`timescale 1ns/1ps
module tb_sram_fifo_rd_unpacker;

  localparam int W  = 32;
  localparam int OW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rd_data;
  logic          fifo_rd_val;
  logic          fifo_rd_req;
  logic          flush;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef SRAM_FIFO_RD_UNPACKER_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   starve_cnt;
`endif

  always #5 clk = ~clk;

  sram_fifo_rd_unpacker #(.SRAM_WRAP_WIDTH(W), .OUT_WIDTH(OW), .PF_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_val  (fifo_rd_val),
    .fifo_rd_req  (fifo_rd_req),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef SRAM_FIFO_RD_UNPACKER_STATS_EN
    .stall_cnt    (stall_cnt),
    .starve_cnt   (starve_cnt),
`endif
    .busy         (busy)
  );

  // ---------------- FIFO model: line store + fixed-latency return pipe ----------------
  logic [W-1:0] fmem [256];
  int           wr_ptr   = 0;
  int           rd_ptr   = 0;
  int           lat      = 2;
  int           issued   = 0;
  int           returned = 0;
  int           empty_rd = 0;
  logic [3:0]   pv       = '0;
  logic [W-1:0] pd [4];

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_val  = pv[lat-1];
  assign fifo_rd_data = pd[lat-1];

  always @(posedge clk) begin
    if (rst) begin
      pv     <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      pv <= {pv[2:0], fifo_rd_req};
      for (int i = 3; i > 0; i--) pd[i] <= pd[i-1];
      if (fifo_rd_req) begin
        if (rd_ptr == wr_ptr) empty_rd <= empty_rd + 1;
        pd[0]  <= fmem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
        issued <= issued + 1;
      end
      if (fifo_rd_val) returned <= returned + 1;
    end
  end

  // ---------------- Output monitor (sampled on the falling edge) ----------------
  logic [OW-1:0] got_q [$];
  int            adj_err  = 0;
  int            stab_err = 0;
  logic          prev_req  = 1'b0;
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_d    = '0;

  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) got_q.push_back(out_data);
    if (fifo_rd_req && prev_req) adj_err++;
    if (prev_hold && (!out_valid || out_data !== prev_d)) stab_err++;
    prev_req  = fifo_rd_req;
    prev_hold = !rst && !flush && out_valid && !out_ready;
    prev_d    = out_data;
  end

  // ---------------- Checking helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_line(input logic [W-1:0] l);
    fmem[wr_ptr] = l;
    wr_ptr++;
  endtask

  // Wait (bounded) until the monitor has collected 'target' slices in total.
  task automatic wait_slices(input int target, input int budget);
    int k;
    k = 0;
    while (got_q.size() < target && k < budget) begin
      tick();
      k++;
    end
  endtask

  // ---------------- Stimulus table ----------------
  // mode: 0 = out_ready held high, 1 = out_ready toggles every cycle, 2 = held low then released
  typedef struct {
    int         nlines;
    int         latency;
    int         mode;
    logic [7:0] first;
    logic [7:0] step;
    int         exp_req_stalled;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int            base, ib, rb, n;
    logic [W-1:0]  line;
    logic [7:0]    b;
    logic [7:0]    exp_b [$];
    logic [W-1:0]  deadbeef;

    vecs[0] = '{nlines: 3,  latency: 2, mode: 0, first: 8'h11, step: 8'h11, exp_req_stalled: 0};
    vecs[1] = '{nlines: 10, latency: 2, mode: 2, first: 8'h11, step: 8'h01, exp_req_stalled: 4};
    vecs[2] = '{nlines: 6,  latency: 1, mode: 1, first: 8'h40, step: 8'h03, exp_req_stalled: 0};
    vecs[3] = '{nlines: 5,  latency: 3, mode: 0, first: 8'hA0, step: 8'h05, exp_req_stalled: 0};

    // ---- reset state ----
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_req", fifo_rd_req, 0);
    tick();
    check("idle_rd_req", fifo_rd_req, 0);

    // ---- table-driven streaming scenarios ----
    for (int v = 0; v < 4; v++) begin
      base = got_q.size();
      ib   = issued;
      n    = vecs[v].nlines * 4;
      lat  = vecs[v].latency;
      exp_b.delete();
      out_ready = (vecs[v].mode != 2);
      for (int l = 0; l < vecs[v].nlines; l++) begin
        line = '0;
        for (int s = 0; s < 4; s++) begin
          b = 8'(int'(vecs[v].first) + int'(vecs[v].step) * (l*4 + s));
          line[s*8 +: 8] = b;
          exp_b.push_back(b);
        end
        load_line(line);
      end
      if (vecs[v].mode == 2) begin
        repeat (30) tick();
        check($sformatf("v%0d_stall_req_cnt", v), issued - ib, vecs[v].exp_req_stalled);
        check($sformatf("v%0d_stall_valid", v), out_valid, 1);
        check($sformatf("v%0d_stall_data", v), out_data, vecs[v].first);
        out_ready = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (got_q.size() - base < n && k < 600) begin
          if (vecs[v].mode == 1) out_ready = ~out_ready;
          tick();
          k++;
        end
      end
      out_ready = 1'b1;
      repeat (12) tick();
      check($sformatf("v%0d_slice_count", v), got_q.size() - base, n);
      for (int j = 0; j < n && (base + j) < got_q.size(); j++) begin
        check($sformatf("v%0d_slice%0d", v, j), got_q[base+j], exp_b[j]);
      end
      check($sformatf("v%0d_lines_read", v), issued - ib, vecs[v].nlines);
      check($sformatf("v%0d_end_valid", v), out_valid, 0);
      check($sformatf("v%0d_end_busy", v), busy, 0);
      check($sformatf("v%0d_rd_req_gap", v), adj_err, 0);
      check($sformatf("v%0d_stall_stable", v), stab_err, 0);
    end

    // ---- flush with 2 lines in flight and 2 buffered ----
    lat = 3; out_ready = 1'b0;
    ib = issued; rb = returned; base = got_q.size();
    for (int i = 0; i < 4; i++) load_line(32'h0101_0101 * (i + 1));
    begin
      int k;
      k = 0;
      while (!((issued - ib) == 4 && (returned - rb) == 2) && k < 60) begin
        tick();
        k++;
      end
    end
    check("flush_setup_inflight", (issued - ib) - (returned - rb), 2);
    check("flush_setup_buffered", returned - rb, 2);
    check("flush_setup_valid", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    #2;
    check("flush_cycle_rd_req", fifo_rd_req, 0);
    tick();
    flush = 1'b0;
    check("flush_valid_next", out_valid, 0);
    check("flush_busy_next", busy, 1);
    begin
      int k;
      k = 0;
      while (busy && k < 60) begin
        tick();
        k++;
      end
    end
    check("flush_busy_falls", busy, 0);
    check("flush_returns_done", returned - rb, 4);
    repeat (4) tick();
    check("flush_no_slices", got_q.size() - base, 0);
    check("flush_stays_idle", out_valid, 0);

    deadbeef = 32'hDEADBEEF;
    base = got_q.size();
    load_line(deadbeef);
    wait_slices(base + 4, 100);
    repeat (6) tick();
    check("reload_count", got_q.size() - base, 4);
    for (int j = 0; j < 4 && (base + j) < got_q.size(); j++) begin
      check($sformatf("reload_slice%0d", j), got_q[base+j], deadbeef[j*8 +: 8]);
    end
    check("reload_busy", busy, 0);

    // ---- reset mid-unpack (idx = 2) ----
    lat = 2; out_ready = 1'b1; base = got_q.size();
    load_line(32'h44332211);
    load_line(32'h88776655);
    wait_slices(base + 2, 100);
    check("rst_pre_slices", got_q.size() - base, 2);
    check("rst_pre_data_idx2", out_data, 8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data", out_data, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_req", fifo_rd_req, 0);
    repeat (6) tick();
    check("rst_mid_quiet", got_q.size() - base, 2);
    base = got_q.size();
    load_line(32'h0A0B0C0D);
    load_line(32'h01020304);
    wait_slices(base + 8, 150);
    repeat (6) tick();
    check("post_rst_count", got_q.size() - base, 8);
    begin
      logic [7:0] post_exp [8];
      post_exp = '{8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h04, 8'h03, 8'h02, 8'h01};
      for (int j = 0; j < 8 && (base + j) < got_q.size(); j++) begin
        check($sformatf("post_rst_slice%0d", j), got_q[base+j], post_exp[j]);
      end
    end
    check("post_rst_busy", busy, 0);

`ifdef SRAM_FIFO_RD_UNPACKER_STATS_EN
    // ---- statistics counters ----
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stats_cleared_stall", stall_cnt, 0);
    check("stats_cleared_starve", starve_cnt, 0);
    repeat (6) tick();
    check("stats_starve5", starve_cnt, 5);
    check("stats_idle_stall", stall_cnt, 0);
    out_ready = 1'b0;
    base = got_q.size();
    load_line(32'hCAFEF00D);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
        tick();
        k++;
      end
    end
    repeat (7) tick();
    check("stats_stall7", stall_cnt, 7);
    out_ready = 1'b1;
    wait_slices(base + 4, 40);
    check("stats_drain", got_q.size() - base, 4);
`endif

    check("final_rd_req_gap", adj_err, 0);
    check("final_stall_stable", stab_err, 0);
    check("final_no_read_on_empty", empty_rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
